// File: rtl/cam_stream_gen_if.sv
// Camera-side pin bundle of the OV7670-style stream: run enable in, PCLK/D/HREF/VSYNC out.
// The master modport is the generator; the slave modport is the capture path.
interface cam_stream_gen_if;
  logic       EN;
  logic       PCLK;
  logic [7:0] D;
  logic       HREF;
  logic       VSYNC;
  logic       FRAME_START;
  logic       BUSY;

  modport master (input EN, output PCLK, D, HREF, VSYNC, FRAME_START, BUSY);
  modport slave  (output EN, input PCLK, D, HREF, VSYNC, FRAME_START, BUSY);
endinterface

// File: rtl/cam_stream_gen.sv
// OV7670-style QCIF colour-bar stream transmitter (PCLK = CLK/2, RGB565 bytes on D).
// Optional macro CAM_GEN_SCROLL_EN: bars shift left by one bar per frame.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 176,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_ACTIVE    = 144,
  parameter int V_FRONT     = 10,
  parameter int BAR_W       = 22
) (
  input  logic CLK,
  input  logic RES,
  cam_stream_gen_if.master cam
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W = $clog2(LINE);
  localparam int ROW_W = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int PIX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE - 1);
  localparam logic [COL_W-1:0] ACT_BYTES = COL_W'(2 * H_ACTIVE);
  localparam logic [ROW_W-1:0] VS_LAST   = ROW_W'(VSYNC_LINES - 1);
  localparam logic [ROW_W-1:0] VB_LAST   = ROW_W'(V_BACK - 1);
  localparam logic [ROW_W-1:0] VA_LAST   = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0] VF_LAST   = ROW_W'(V_FRONT - 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(BAR_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
  } state_t;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [ROW_W-1:0] seg_last;
  logic [2:0]       bar_reg;
  logic [PIX_W-1:0] pix_reg;
  logic [2:0]       start_bar;
  logic             pclk_reg;
  logic             frame_start_reg;
  logic             start_frame;
  logic             line_end;
  logic             seg_end;
  logic             tick;
  logic             href;
  logic [15:0]      rgb;
  logic [7:0]       d;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // A tick is the CLK edge on which PCLK falls.
  assign tick     = pclk_reg;
  assign line_end = (col_reg == COL_LAST);
  assign seg_end  = line_end && (row_reg == seg_last);

`ifdef CAM_GEN_SCROLL_EN
  logic [2:0] frame_cnt_reg;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      frame_cnt_reg <= 3'd0;
    end else if (tick && start_frame) begin
      frame_cnt_reg <= frame_cnt_reg + 3'd1;
    end
  end

  // The counter has already advanced past the current frame by its first active line.
  assign start_bar = frame_cnt_reg - 3'd1;
`else
  assign start_bar = 3'd0;
`endif

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_reg       <= ST_IDLE;
      col_reg         <= '0;
      row_reg         <= '0;
      pclk_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      bar_reg         <= 3'd0;
      pix_reg         <= '0;
    end else begin
      pclk_reg        <= ~pclk_reg;
      frame_start_reg <= tick && start_frame;
      if (tick) begin
        state_reg <= state_next;
        col_reg   <= col_next;
        row_reg   <= row_next;
        if (col_next == '0) begin
          bar_reg <= start_bar;
          pix_reg <= '0;
        end else if (href && col_reg[0]) begin
          if (pix_reg == PIX_LAST) begin
            pix_reg <= '0;
            bar_reg <= bar_reg + 3'd1;
          end else begin
            pix_reg <= pix_reg + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    seg_last    = '0;
    state_next  = state_reg;
    col_next    = line_end ? '0 : col_reg + 1'b1;
    row_next    = line_end ? row_reg + 1'b1 : row_reg;
    start_frame = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        col_next = '0;
        row_next = '0;
        if (cam.EN) begin
          state_next  = ST_VSYNC;
          start_frame = 1'b1;
        end
      end
      ST_VSYNC: begin
        seg_last = VS_LAST;
        if (seg_end) begin
          state_next = ST_VBACK;
          row_next   = '0;
        end
      end
      ST_VBACK: begin
        seg_last = VB_LAST;
        if (seg_end) begin
          state_next = ST_ACTIVE;
          row_next   = '0;
        end
      end
      ST_ACTIVE: begin
        seg_last = VA_LAST;
        if (seg_end) begin
          state_next = ST_VFRONT;
          row_next   = '0;
        end
      end
      ST_VFRONT: begin
        seg_last = VF_LAST;
        if (seg_end) begin
          row_next = '0;
          if (cam.EN) begin
            state_next  = ST_VSYNC;
            start_frame = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    href = (state_reg == ST_ACTIVE) && (col_reg < ACT_BYTES);
    rgb  = bar_color(bar_reg);
    d    = 8'h00;
    if (href) begin
      d = col_reg[0] ? rgb[7:0] : rgb[15:8];
    end
  end

  assign cam.PCLK        = pclk_reg;
  assign cam.D           = d;
  assign cam.HREF        = href;
  assign cam.VSYNC       = (state_reg == ST_VSYNC);
  assign cam.FRAME_START = frame_start_reg;
  assign cam.BUSY        = (state_reg != ST_IDLE);

endmodule
